// File: rtl/ram_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share the 16x8 single-port RAM.
// One transaction is in flight at a time: IDLE -> ACCESS -> (RD_WAIT) -> RESP -> IDLE.
module ram_arbiter #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_valid,
    input  logic [1:0]    req_we,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    output logic [1:0]    req_ready,
    output logic [1:0]    rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          ram_we,
    output logic          ram_re,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          prio_r;
    logic          prio_s;
    logic          owner_r;
    logic          owner_s;
    logic          win_s;
    logic          we_s;
    logic          re_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] din_s;
    logic [1:0]    rsp_valid_s;
    logic [DW-1:0] rdata_s;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Arbitration, next-state and next-value decode for every registered output.
    always_comb begin
        state_s     = state_r;
        prio_s      = prio_r;
        owner_s     = owner_r;
        win_s       = 1'b0;
        req_ready   = 2'b00;
        we_s        = 1'b0;
        re_s        = 1'b0;
        addr_s      = ram_addr;
        din_s       = ram_din;
        rsp_valid_s = 2'b00;
        rdata_s     = rsp_rdata;
        case (state_r)
            IDLE: begin
                // Ready is held low during reset even though the state register already reads IDLE.
                if (!rst && (req_valid != 2'b00)) begin
                    if (req_valid == 2'b11) begin
                        win_s = prio_r;
                    end else begin
                        win_s = req_valid[1];
                    end
                    req_ready = onehot(win_s);
                    owner_s   = win_s;
                    prio_s    = ~win_s;
                    we_s      = req_we[win_s];
                    re_s      = ~req_we[win_s];
                    addr_s    = win_s ? req_addr1 : req_addr0;
                    din_s     = win_s ? req_wdata1 : req_wdata0;
                    state_s   = ACCESS;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                if (ram_we) begin
                    state_s     = RESP;
                    rsp_valid_s = onehot(owner_r);
                end else begin
                    state_s = RD_WAIT;
                end
            end
            RD_WAIT: begin
                rdata_s     = ram_dout;
                rsp_valid_s = onehot(owner_r);
                state_s     = RESP;
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Control state: FSM, round-robin pointer and transaction owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            prio_r  <= 1'b0;
            owner_r <= 1'b0;
        end else begin
            state_r <= state_s;
            prio_r  <= prio_s;
            owner_r <= owner_s;
        end
    end

    // Registered RAM pins, response and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_re    <= 1'b0;
            ram_addr  <= {AW{1'b0}};
            ram_din   <= {DW{1'b0}};
            rsp_valid <= 2'b00;
            rsp_rdata <= {DW{1'b0}};
            busy      <= 1'b0;
        end else begin
            ram_we    <= we_s;
            ram_re    <= re_s;
            ram_addr  <= addr_s;
            ram_din   <= din_s;
            rsp_valid <= rsp_valid_s;
            rsp_rdata <= rdata_s;
            busy      <= (state_s != IDLE);
        end
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-requester round-robin arbiter and sequencer for the 16x8 single-port RAM (`ram`: ports clk, rst, we, re, addr, din, dout). Each requester issues single read or write transactions over a valid/ready handshake. The block serialises those transactions onto the RAM's we/re/addr/din pins and returns a one-cycle response pulse, with read data, to the requester that issued the transaction. It sits between the RAM and its two clients; nothing else drives the RAM.

## Interface
- AW, 4, RAM address width (16 words)
- DW, 8, RAM data width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester command valid, bit i = requester i
- req_we  in  2  per-requester command type: 1 = write, 0 = read
- req_addr0 / req_addr1  in  AW  command address, requester 0 / 1
- req_wdata0 / req_wdata1  in  DW  write data, requester 0 / 1
- req_ready  out  2  command accepted this cycle (one-hot or zero)
- rsp_valid  out  2  one-cycle completion pulse, bit i = requester i
- rsp_rdata  out  DW  read data, valid while the rsp_valid bit of a read is high
- ram_we  out  1  to RAM we
- ram_re  out  1  to RAM re
- ram_addr  out  AW  to RAM addr
- ram_din  out  DW  to RAM din
- ram_dout  in  DW  from RAM dout
- busy  out  1  high in every state except IDLE

## Operation
- The RAM writes on the rising edge where we=1. It returns read data on dout in the cycle after the edge that samples re=1.
- FSM states: IDLE, ACCESS, RD_WAIT, RESP.
- IDLE: if any req_valid bit is set, the arbiter picks a winner. req_ready is asserted combinationally for the winner only.
  - The handshake is valid & ready. On that edge the block registers the winner's we/addr/wdata into ram_we/ram_re/ram_addr/ram_din and the FSM moves to ACCESS.
- Arbitration:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester selected by prio is granted.
  - prio resets to 0. On every grant, prio is set to the non-winning index.
- ACCESS: exactly one cycle with ram_we=1 (write) or ram_re=1 (read), never both. Next state is RESP for a write, RD_WAIT for a read.
- RD_WAIT: ram_we and ram_re are 0. ram_dout is captured into rsp_rdata at the end of the cycle. Next state is RESP.
- RESP: the owner's rsp_valid bit is high for exactly one cycle. The FSM then returns to IDLE.
  - There is no response back-pressure; the requester must accept the pulse.
  - For a write response, rsp_rdata keeps its previous value.
- ram_addr and ram_din hold their last values outside ACCESS. Only ram_we and ram_re qualify them.
- Requester obligations: hold req_valid, req_we, req_addr and req_wdata stable until ready is seen. A requester may drop valid before it is granted; the arbiter then ignores it.
- No new command is accepted while busy. req_ready is 0 in all states except IDLE.

## Timing
- Reset values, applied immediately on rst and held while rst=1:
  - ram_we=0, ram_re=0, ram_addr=0, ram_din=0.
  - rsp_valid=00, rsp_rdata=0, req_ready=00, busy=0.
  - state=IDLE, prio=0.
- Reset mid-transaction: the FSM goes to IDLE, the in-flight transaction is dropped, and no rsp_valid is issued. A write already sampled by the RAM is not undone.
- Let cycle 0 be the handshake cycle.
  - Write: ram_we=1 in cycle 1, rsp_valid in cycle 2, next accept possible in cycle 3.
  - Read: ram_re=1 in cycle 1, RD_WAIT in cycle 2, rsp_valid with rsp_rdata in cycle 3, next accept possible in cycle 4.
- Peak throughput is one write per 3 cycles or one read per 4 cycles.
- Both valid continuously: grants strictly alternate 0,1,0,1. Neither requester waits more than one transaction.
- A requester that asserts valid in the same cycle the FSM returns to IDLE is arbitrated in that cycle.
- busy is registered and equals (state != IDLE).

## Test plan
- Reset then idle: rst=1 for 2 cycles mid-clock. All outputs read 0 asynchronously, and no ram_we/ram_re pulses appear while req_valid=00.
- Single write then read, requester 0:
  - Write addr 1 = AA: ram_we=1, addr=1, din=AA in cycle 1, and rsp_valid=01 in cycle 2.
  - Then read addr 1: ram_re=1 in cycle 1, and rsp_valid=01 with rsp_rdata=AA in cycle 3.
- Contention: both requesters valid from reset, req0 writes addr 2=BB and req1 writes addr 3=CC. Grant order is req0 then req1.
  - Both then read addr 2/3 back. Grants alternate, and the responses are BB to req0 and CC to req1.
- Fairness: both requesters hold valid with reads for 8 transactions. req_ready alternates 01,10,01,...
  - No two consecutive grants go to the same requester, and rsp_valid bits match the grant order.
- Stall and withdrawal:
  - req1 is valid while busy: req_ready stays 00 until IDLE.
  - req0 drops valid before grant: no access is issued for it.
- Reset mid-read: assert rst during RD_WAIT. No rsp_valid follows. After release, a read of addr 1 returns AA, and RAM contents are unaffected.
